// File: rtl/seq_wide_adder_ctrl_pkg.sv
// Shared constants, FSM state encoding and a width helper for the
// nibble-serial wide adder sequencer.
package seq_wide_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_wide_adder_ctrl_fulladd4.sv
// 4-bit ripple-carry adder used as the single shared datapath slice.
module fulladd4
  import seq_wide_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// WIDTH-bit adder that walks one shared fulladd4 across the operands a
// nibble per cycle, with valid/ready handshakes on both sides.
module seq_wide_adder_ctrl
  import seq_wide_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("seq_wide_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg;
  logic                  carry_reg;
  logic [WIDTH-1:0]      a_r, b_r, sum_reg;
  logic                  c_out_reg;

  logic [NIBBLE_W-1:0]   a_nib [NIB];
  logic [NIBBLE_W-1:0]   b_nib [NIB];
  logic [NIBBLE_W-1:0]   add_sum;
  logic                  add_co;

  for (genvar gi = 0; gi < NIB; gi++) begin : g_slice
    assign a_nib[gi] = a_r[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_r[gi*NIBBLE_W +: NIBBLE_W];
  end

  fulladd4 u_add (
    .a     (a_nib[idx_reg]),
    .b     (b_nib[idx_reg]),
    .c_in  (carry_reg),
    .sum   (add_sum),
    .c_out (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are frozen at accept; sum nibbles fill in LSB-first during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_r       <= a;
            b_r       <= b;
            carry_reg <= c_in;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx_reg == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= add_sum;
          end
          carry_reg <= add_co;
          if (idx_reg == LAST_IDX) begin
            c_out_reg <= add_co;
            idx_reg   <= '0;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;

endmodule
